ex_stage: RTL and testbench
===========================

EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, and all state SHALL update on the falling edge of clk, the pipeline-latch edge.
REQ-002 Ports SHALL be exactly:
- clk, input, 1: pipeline clock.
- rst, input, 1: asynchronous active-high reset.
- id_ex, input, 164: ID/EX bundle, packed as {sign_ext32[163:132], rs_val[131:100], rt_val[99:68], lower26[67:42], new_pc[41:10], ctrl[9:0]}.
- stall, output, 1: hold request to the upstream stages while a multiply is in progress.
- ex_mem, output, 108: EX/MEM bundle, packed as {alu_result[107:76], store_data[75:44], branch_target[43:12], dest_reg[11:7], branch_taken[6], reg_write[5], mem_read[4], mem_write[3], mem_to_reg[2], valid[1], mul_done[0]}.
REQ-003 The ctrl fields SHALL be decoded as follows:
- [9] reg_write
- [8] mem_read
- [7] mem_write
- [6] mem_to_reg
- [5] reg_dst
- [4] alu_src
- [3:1] alu_op
- [0] branch
REQ-004 An all-zero id_ex (bubble) SHALL be treated as a no-op and SHALL produce valid=0.

Function
REQ-005 Operand A SHALL be rs_val; operand B SHALL be sign_ext32 when alu_src=1, else rt_val.
REQ-006 alu_op SHALL select the operation:
- 000: add.
- 001: subtract.
- 010: AND.
- 011: OR.
- 100: signed set-less-than, giving 1 or 0.
- 101: rt_val shifted left by lower26[10:6].
- 110: subtract, result used for compare.
- 111: multiply.
REQ-007 All arithmetic SHALL be modulo 2^32, with overflow ignored and no exception.
REQ-008 dest_reg SHALL be lower26[15:11] when reg_dst=1, else lower26[20:16].
REQ-009 store_data SHALL equal rt_val.
REQ-010 branch_taken SHALL be 1 iff branch=1 and rs_val==rt_val.
REQ-011 branch_target SHALL be new_pc + (sign_ext32<<2), computed every cycle.
REQ-012 Single-cycle ops (alu_op != 111) SHALL appear on ex_mem one falling edge after id_ex is presented, with valid=1 and mul_done=0.
REQ-013 Multiply SHALL use a state machine with states IDLE, MUL and DONE.
REQ-014 IDLE→MUL SHALL occur on an edge where alu_op=111 and valid input; on that edge the multiplicand, multiplier, control and dest_reg SHALL be latched, the 6-bit count SHALL be set to 0 and the accumulator SHALL be cleared.
REQ-015 In MUL, each edge SHALL run one shift-add step: if multiplier[0], add the multiplicand to the accumulator; then shift the multiplicand left, shift the multiplier right and increment the count.
REQ-016 MUL→DONE SHALL occur when the count reaches 32.
REQ-017 The product SHALL be the low 32 bits.
REQ-018 DONE→IDLE SHALL occur on the next edge; on that edge ex_mem SHALL load the product with valid=1 and mul_done=1.
REQ-019 stall SHALL be combinationally 1 in MUL, and also in IDLE when the current id_ex has alu_op=111 and valid input.
REQ-020 stall SHALL be 0 in DONE.
REQ-021 Total multiply latency SHALL be 34 edges from acceptance to the ex_mem result.
REQ-022 While in MUL, id_ex SHALL be ignored, and ex_mem SHALL load all zeros (bubble) on each edge.
REQ-023 A multiply with branch=1 SHALL have branch_taken forced to 0.
REQ-024 Back-to-back multiplies SHALL each take full latency.
REQ-025 The instruction presented during DONE SHALL be accepted on the IDLE edge that follows.

Reset
REQ-026 rst=1 SHALL immediately, without waiting for clk, force state=IDLE, count=0, accumulator=0 and ex_mem=108'b0; stall SHALL then reflect only the IDLE decode.
REQ-027 Reset mid-multiply SHALL abort the operation, and no partial result SHALL ever appear on ex_mem.
REQ-028 After rst deasserts, the first falling edge SHALL process id_ex normally.

Verification
REQ-029 The bench SHALL cover add: rs_val=5, rt_val=7, alu_op=000, alu_src=0, reg_write=1, reg_dst=1, lower26[15:11]=3 → next edge alu_result=12, dest_reg=3, valid=1.
REQ-030 The bench SHALL cover immediate subtract wrap: rs_val=0, sign_ext32=1, alu_src=1, alu_op=001 → alu_result=0xFFFFFFFF.
REQ-031 The bench SHALL cover branch: branch=1, rs_val=rt_val=9, new_pc=0x100, sign_ext32=0xFFFFFFFE → branch_taken=1, branch_target=0xF8; with rt_val=8 → branch_taken=0.
REQ-032 The bench SHALL cover multiply: rs_val=0xFFFF, rt_val=0x10001, alu_op=111 → stall high for 33 edges, bubbles meanwhile, then alu_result=0xFFFFFFFF, mul_done=1.
REQ-033 The bench SHALL cover reset mid-multiply: assert rst at count=10 between edges → ex_mem=0 and stall reflects only the IDLE decode immediately; after release an add completes normally with no stale product.
REQ-034 The bench SHALL cover slt/shift: rs_val=0x80000000, rt_val=1, alu_op=100 → 1; rt_val=3, shamt=4, alu_op=101 → 0x30.

Source files
------------

// File: rtl/ex_stage.sv
// ex_stage: execute stage with single-cycle ALU, branch resolution and a 34-edge shift-add multiplier.
// All state updates on the falling edge of clk.
module ex_stage (
  input  logic         clk,
  input  logic         rst,
  input  logic [163:0] id_ex,
  output logic         stall,
  output logic [107:0] ex_mem
);
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
  state_t state_q, state_d;
  logic [31:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d, rt_q, rt_d;
  logic [5:0] cnt_q, cnt_d;
  logic [9:0] ctrl_q, ctrl_d;
  logic [4:0] dest_q, dest_d;
  logic [107:0] ex_mem_q, ex_mem_d;
  logic [31:0] se, rs, rt, pc, op_b, alu, br_tgt;
  logic [25:0] l26;
  logic [9:0] ctrl;
  logic [2:0] op;
  logic [4:0] dest;
  logic in_valid, is_mul, br_taken, slt, unused;
  assign {se, rs, rt, l26, pc, ctrl} = id_ex;
  assign op = ctrl[3:1];
  assign in_valid = |id_ex;
  assign is_mul = in_valid && op == 3'b111;
  assign op_b = ctrl[4] ? se : rt;
  assign dest = ctrl[5] ? l26[15:11] : l26[20:16];
  assign br_taken = ctrl[0] && rs == rt;
  assign br_tgt = pc + {se[29:0], 2'b00};
  assign slt = $signed(rs) < $signed(op_b);
  assign unused = ^{l26[25:21], l26[5:0]};
  assign alu = op == 3'd0 ? rs + op_b :
               op == 3'd1 ? rs - op_b :
               op == 3'd2 ? rs & op_b :
               op == 3'd3 ? rs | op_b :
               op == 3'd4 ? {31'b0, slt} :
               op == 3'd5 ? rt << l26[10:6] :
               op == 3'd6 ? rs - op_b : 32'h0;
  assign stall = state_q == MUL || (state_q == IDLE && is_mul);
  assign ex_mem = ex_mem_q;
  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    mplier_d = mplier_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    ctrl_d = ctrl_q;
    dest_d = dest_q;
    rt_d = rt_q;
    ex_mem_d = '0;
    case (state_q)
      IDLE: if (is_mul) begin
        state_d = MUL;
        mcand_d = rs;
        mplier_d = op_b;
        acc_d = '0;
        cnt_d = '0;
        ctrl_d = ctrl;
        dest_d = dest;
        rt_d = rt;
      end else ex_mem_d = {alu, rt, br_tgt, dest, br_taken, ctrl[9:6], in_valid, 1'b0};
      MUL: begin
        acc_d = mplier_q[0] ? acc_q + mcand_q : acc_q;
        mcand_d = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d = cnt_q + 6'd1;
        state_d = cnt_q == 6'd31 ? DONE : MUL;
      end
      DONE: begin
        state_d = IDLE;
        ex_mem_d = {acc_q, rt_q, br_tgt, dest_q, 1'b0, ctrl_q[9:6], 1'b1, 1'b1};
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mcand_q <= '0;
      mplier_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      ctrl_q <= '0;
      dest_q <= '0;
      rt_q <= '0;
      ex_mem_q <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      mplier_q <= mplier_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      ctrl_q <= ctrl_d;
      dest_q <= dest_d;
      rt_q <= rt_d;
      ex_mem_q <= ex_mem_d;
    end
  end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed self-checking bench for ex_stage; samples on rising edge, DUT latches on falling edge.
module tb_ex_stage;
  logic clk, rst;
  logic [163:0] id_ex;
  logic stall;
  logic [107:0] ex_mem;
  int pass, total;

  ex_stage dut (.clk(clk), .rst(rst), .id_ex(id_ex), .stall(stall), .ex_mem(ex_mem));

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [9:0] mk(input logic rw, rd, as, br, input logic [2:0] op);
    return {rw, 3'b000, rd, as, op, br};
  endfunction

  function automatic logic [163:0] pk(input logic [31:0] se, rs, rt, input logic [25:0] l26,
                                      input logic [31:0] pc, input logic [9:0] c);
    return {se, rs, rt, l26, pc, c};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    total++; if (ex_mem !== 108'b0) $display("FAIL reset_ex_mem got=%h exp=0", ex_mem); else pass++;
    total++; if (stall !== 1'b0) $display("FAIL reset_stall got=%b exp=0", stall); else pass++;
    id_ex = pk(0, 2, 3, 0, 0, mk(1, 1, 0, 0, 3'b111));
    #1;
    total++; if (stall !== 1'b1) $display("FAIL reset_stall_decode got=%b exp=1", stall); else pass++;
    id_ex = '0;
    step();
    rst = 0;
  endtask

  task automatic test_add();
    id_ex = pk(0, 5, 7, 26'(3 << 11), 0, mk(1, 1, 0, 0, 3'b000));
    step();
    total++; if (ex_mem[107:76] !== 32'd12) $display("FAIL add_result got=%h exp=c", ex_mem[107:76]); else pass++;
    total++; if (ex_mem[11:7] !== 5'd3) $display("FAIL add_dest got=%0d exp=3", ex_mem[11:7]); else pass++;
    total++; if (ex_mem[5:0] !== 6'b100010) $display("FAIL add_flags got=%b exp=100010", ex_mem[5:0]); else pass++;
    total++; if (ex_mem[75:44] !== 32'd7) $display("FAIL add_store got=%h exp=7", ex_mem[75:44]); else pass++;
  endtask

  task automatic test_bubble();
    id_ex = '0;
    step();
    total++; if (ex_mem !== 108'b0) $display("FAIL bubble got=%h exp=0", ex_mem); else pass++;
  endtask

  task automatic test_sub_imm();
    id_ex = pk(1, 0, 32'h55, 26'(5 << 16), 0, mk(1, 0, 1, 0, 3'b001));
    step();
    total++; if (ex_mem[107:76] !== 32'hFFFFFFFF) $display("FAIL subi_result got=%h exp=ffffffff", ex_mem[107:76]); else pass++;
    total++; if (ex_mem[11:7] !== 5'd5) $display("FAIL subi_dest got=%0d exp=5", ex_mem[11:7]); else pass++;
  endtask

  task automatic test_branch();
    id_ex = pk(32'hFFFFFFFE, 9, 9, 0, 32'h100, mk(0, 0, 0, 1, 3'b110));
    step();
    total++; if (ex_mem[6] !== 1'b1) $display("FAIL br_taken got=%b exp=1", ex_mem[6]); else pass++;
    total++; if (ex_mem[43:12] !== 32'hF8) $display("FAIL br_target got=%h exp=f8", ex_mem[43:12]); else pass++;
    id_ex = pk(32'hFFFFFFFE, 9, 8, 0, 32'h100, mk(0, 0, 0, 1, 3'b110));
    step();
    total++; if (ex_mem[6] !== 1'b0) $display("FAIL br_not_taken got=%b exp=0", ex_mem[6]); else pass++;
    total++; if (ex_mem[107:76] !== 32'd1) $display("FAIL br_cmp got=%h exp=1", ex_mem[107:76]); else pass++;
  endtask

  task automatic test_slt_shift_logic();
    id_ex = pk(0, 32'h80000000, 1, 0, 0, mk(1, 1, 0, 0, 3'b100));
    step();
    total++; if (ex_mem[107:76] !== 32'd1) $display("FAIL slt got=%h exp=1", ex_mem[107:76]); else pass++;
    id_ex = pk(0, 32'h12345678, 3, 26'(4 << 6), 0, mk(1, 1, 0, 0, 3'b101));
    step();
    total++; if (ex_mem[107:76] !== 32'h30) $display("FAIL sll got=%h exp=30", ex_mem[107:76]); else pass++;
    id_ex = pk(0, 32'hF0F0, 32'hFF00, 0, 0, mk(1, 1, 0, 0, 3'b010));
    step();
    total++; if (ex_mem[107:76] !== 32'hF000) $display("FAIL and got=%h exp=f000", ex_mem[107:76]); else pass++;
    id_ex = pk(0, 32'hF0F0, 32'hFF00, 0, 0, mk(1, 1, 0, 0, 3'b011));
    step();
    total++; if (ex_mem[107:76] !== 32'hFFF0) $display("FAIL or got=%h exp=fff0", ex_mem[107:76]); else pass++;
  endtask

  task automatic test_mul();
    int n, bad;
    id_ex = pk(0, 32'hFFFF, 32'h10001, 26'(2 << 11), 0, mk(1, 1, 0, 0, 3'b111));
    #1;
    n = stall ? 1 : 0;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (ex_mem !== 108'b0) bad++;
      if (!stall) break;
      n++;
    end
    total++; if (n !== 33) $display("FAIL mul_stall_edges got=%0d exp=33", n); else pass++;
    total++; if (bad !== 0) $display("FAIL mul_bubbles got=%0d exp=0", bad); else pass++;
    id_ex = pk(0, 5, 7, 26'(3 << 11), 0, mk(1, 1, 0, 0, 3'b000));
    step();
    total++; if (ex_mem[107:76] !== 32'hFFFFFFFF) $display("FAIL mul_product got=%h exp=ffffffff", ex_mem[107:76]); else pass++;
    total++; if (ex_mem[1:0] !== 2'b11) $display("FAIL mul_valid_done got=%b exp=11", ex_mem[1:0]); else pass++;
    total++; if (ex_mem[11:7] !== 5'd2) $display("FAIL mul_dest got=%0d exp=2", ex_mem[11:7]); else pass++;
    step();
    total++; if (ex_mem[107:76] !== 32'd12 || ex_mem[0] !== 1'b0) $display("FAIL after_mul_add got=%h exp=c", ex_mem[107:76]); else pass++;
  endtask

  task automatic test_back_to_back();
    int n;
    id_ex = pk(0, 3, 3, 0, 0, mk(1, 0, 0, 1, 3'b111));
    #1;
    n = stall ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (!stall) break;
      n++;
    end
    total++; if (n !== 33) $display("FAIL b2b_first_edges got=%0d exp=33", n); else pass++;
    id_ex = pk(0, 4, 5, 0, 0, mk(1, 0, 0, 0, 3'b111));
    step();
    total++; if (ex_mem[107:76] !== 32'd9) $display("FAIL b2b_first_product got=%h exp=9", ex_mem[107:76]); else pass++;
    total++; if (ex_mem[6] !== 1'b0) $display("FAIL mul_branch_forced got=%b exp=0", ex_mem[6]); else pass++;
    n = stall ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (!stall) break;
      n++;
    end
    total++; if (n !== 33) $display("FAIL b2b_second_edges got=%0d exp=33", n); else pass++;
    id_ex = '0;
    step();
    total++; if (ex_mem[107:76] !== 32'd20 || ex_mem[0] !== 1'b1) $display("FAIL b2b_second_product got=%h exp=14", ex_mem[107:76]); else pass++;
  endtask

  task automatic test_reset_mid_mul();
    int bad;
    id_ex = pk(0, 5, 7, 0, 0, mk(1, 1, 0, 0, 3'b111));
    repeat (11) step();
    total++; if (stall !== 1'b1) $display("FAIL mid_stall_busy got=%b exp=1", stall); else pass++;
    rst = 1;
    #1;
    total++; if (ex_mem !== 108'b0) $display("FAIL mid_rst_ex_mem got=%h exp=0", ex_mem); else pass++;
    total++; if (stall !== 1'b1) $display("FAIL mid_rst_stall_decode got=%b exp=1", stall); else pass++;
    id_ex = pk(0, 5, 7, 26'(3 << 11), 0, mk(1, 1, 0, 0, 3'b000));
    #1;
    total++; if (stall !== 1'b0) $display("FAIL mid_rst_stall_idle got=%b exp=0", stall); else pass++;
    step();
    rst = 0;
    step();
    total++; if (ex_mem[107:76] !== 32'd12 || ex_mem[1:0] !== 2'b10) $display("FAIL mid_post_add got=%h exp=c", ex_mem[107:76]); else pass++;
    id_ex = '0;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (ex_mem !== 108'b0 || stall !== 1'b0) bad++;
    end
    total++; if (bad !== 0) $display("FAIL mid_no_stale got=%0d exp=0", bad); else pass++;
  endtask

  initial begin
    pass = 0;
    total = 0;
    rst = 1;
    id_ex = '0;
    #1;
    test_reset();
    test_add();
    test_bubble();
    test_sub_imm();
    test_branch();
    test_slt_shift_logic();
    test_mul();
    test_back_to_back();
    test_reset_mid_mul();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
